// File: rtl/dda_pkg.sv
// Shared types and helpers for the van der Pol DDA solver.
// Latency: combinational helpers only.
// Backpressure: not applicable.
package dda_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SQ,
    S_MU,
    S_DY,
    S_UPD,
    S_HOLD
  } state_t;

  localparam logic [1:0] CFG_MU = 2'd0;
  localparam logic [1:0] CFG_DT = 2'd1;
  localparam logic [1:0] CFG_X0 = 2'd2;
  localparam logic [1:0] CFG_Y0 = 2'd3;

  // Saturating add of two sign-extended operands, clipped to a w-bit signed range (w <= 31).
  function automatic logic signed [31:0] sat_add(input logic signed [31:0] a,
                                                 input logic signed [31:0] b,
                                                 input int w);
    logic signed [32:0] s, hi, lo, r;
    s  = 33'(a) + 33'(b);
    hi = (33'sd1 <<< (w - 1)) - 33'sd1;
    lo = -(33'sd1 <<< (w - 1));
    if (s > hi)      r = hi;
    else if (s < lo) r = lo;
    else             r = s;
    return 32'(r);
  endfunction

  // Companion to sat_add: 1 when the same add would clip.
  function automatic logic sat_ovf(input logic signed [31:0] a,
                                   input logic signed [31:0] b,
                                   input int w);
    logic signed [32:0] s, hi, lo;
    s  = 33'(a) + 33'(b);
    hi = (33'sd1 <<< (w - 1)) - 33'sd1;
    lo = -(33'sd1 <<< (w - 1));
    return (s > hi) || (s < lo);
  endfunction

endpackage

// File: rtl/dda_sat_mul.sv
// Signed fixed-point multiply: full product, floor shift by FRAC, saturate to WIDTH.
// Latency: combinational.
// Backpressure: not applicable.
module dda_sat_mul #(
  parameter int WIDTH = 16,
  parameter int FRAC  = 12
) (
  input  logic signed [WIDTH-1:0] i_a,
  input  logic signed [WIDTH-1:0] i_b,
  output logic signed [WIDTH-1:0] o_p,
  output logic                    o_ovf
);

  localparam logic signed [2*WIDTH-1:0] P_MAX = $signed({{(WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}});
  localparam logic signed [2*WIDTH-1:0] P_MIN = $signed({{(WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}});

  logic signed [2*WIDTH-1:0] w_full;
  logic signed [2*WIDTH-1:0] w_shf;

  assign w_full = (2*WIDTH)'(i_a) * (2*WIDTH)'(i_b);
  assign w_shf  = w_full >>> FRAC;

  // Clip the shifted product into the WIDTH-bit signed range and flag any clip.
  always_comb begin
    o_ovf = 1'b0;
    o_p   = w_shf[WIDTH-1:0];
    if (w_shf > P_MAX) begin
      o_ovf = 1'b1;
      o_p   = {1'b0, {(WIDTH-1){1'b1}}};
    end else if (w_shf < P_MIN) begin
      o_ovf = 1'b1;
      o_p   = {1'b1, {(WIDTH-1){1'b0}}};
    end
  end

endmodule

// File: rtl/dda_vdp_solver.sv
// Van der Pol forward-Euler solver with one time-shared saturating multiplier.
// Latency: one step every 5 cycles (SQ, MU, DY, UPD, HOLD); first sample 5 cycles after run.
// Backpressure: sample held in HOLD with x, y, step_cnt frozen until out_ready.
module dda_vdp_solver
  import dda_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int FRAC    = 12,
  parameter int CNT_W   = 16,
  parameter int X0_INIT = 1 << FRAC,
  parameter int MU_INIT = 1 << FRAC,
  parameter int DT_INIT = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_ena,
  input  logic             i_run,
  input  logic             i_cfg_we,
  input  logic [1:0]       i_cfg_sel,
  input  logic [WIDTH-1:0] i_cfg_data,
  input  logic             i_out_ready,
  output logic             o_out_valid,
  output logic [WIDTH-1:0] o_x_out,
  output logic [WIDTH-1:0] o_y_out,
  output logic             o_busy,
  output logic             o_sat,
  output logic [CNT_W-1:0] o_step_cnt
);

  localparam logic signed [31:0] ONE32 = 32'sd1 <<< FRAC;

  state_t                  r_state, w_state_nxt;
  logic signed [WIDTH-1:0] r_x, r_y, r_mu, r_p;
  logic [3:0]              r_dt;
  logic                    r_valid, r_sat;
  logic [CNT_W-1:0]        r_cnt;

  logic signed [WIDTH-1:0] w_mul_a, w_mul_b, w_mul_p;
  logic                    w_mul_ovf;
  logic signed [WIDTH-1:0] w_omp, w_y_sh, w_x_nxt, w_d, w_d_sh, w_y_nxt;
  logic                    w_omp_ovf, w_x_ovf, w_d_ovf, w_y_ovf;

  // (1 - p) feeding the mu stage
  assign w_omp     = WIDTH'(sat_add(ONE32, -(32'(r_p)), WIDTH));
  assign w_omp_ovf = sat_ovf(ONE32, -(32'(r_p)), WIDTH);

  // Euler update terms, all from the pre-step x and y
  assign w_y_sh  = r_y >>> r_dt;
  assign w_x_nxt = WIDTH'(sat_add(32'(r_x), 32'(w_y_sh), WIDTH));
  assign w_x_ovf = sat_ovf(32'(r_x), 32'(w_y_sh), WIDTH);
  assign w_d     = WIDTH'(sat_add(32'(r_p), -(32'(r_x)), WIDTH));
  assign w_d_ovf = sat_ovf(32'(r_p), -(32'(r_x)), WIDTH);
  assign w_d_sh  = w_d >>> r_dt;
  assign w_y_nxt = WIDTH'(sat_add(32'(r_y), 32'(w_d_sh), WIDTH));
  assign w_y_ovf = sat_ovf(32'(r_y), 32'(w_d_sh), WIDTH);

  // Route the shared multiplier operands for the current product stage.
  always_comb begin
    w_mul_a = r_x;
    w_mul_b = r_x;
    case (r_state)
      S_MU: begin
        w_mul_a = r_mu;
        w_mul_b = w_omp;
      end
      S_DY: begin
        w_mul_a = r_p;
        w_mul_b = r_y;
      end
      default: ;
    endcase
  end

  dda_sat_mul #(
    .WIDTH (WIDTH),
    .FRAC  (FRAC)
  ) u_mul (
    .i_a   (w_mul_a),
    .i_b   (w_mul_b),
    .o_p   (w_mul_p),
    .o_ovf (w_mul_ovf)
  );

  // State register; ena=0 freezes the sequence.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)   r_state <= S_IDLE;
    else if (i_ena) r_state <= w_state_nxt;
  end

  // Next-state: fixed product pipeline, then wait for the sink in HOLD.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (i_run) w_state_nxt = S_SQ;
      S_SQ:    w_state_nxt = S_MU;
      S_MU:    w_state_nxt = S_DY;
      S_DY:    w_state_nxt = S_UPD;
      S_UPD:   w_state_nxt = S_HOLD;
      S_HOLD:  if (r_valid && i_out_ready) w_state_nxt = i_run ? S_SQ : S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Datapath, config registers, output stream and step counter.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_x     <= WIDTH'(X0_INIT);
      r_y     <= '0;
      r_mu    <= WIDTH'(MU_INIT);
      r_dt    <= 4'(DT_INIT);
      r_p     <= '0;
      r_valid <= 1'b0;
      r_sat   <= 1'b0;
      r_cnt   <= '0;
    end else if (i_ena) begin
      case (r_state)
        S_IDLE: begin
          if (i_cfg_we) begin
            case (i_cfg_sel)
              CFG_MU:  r_mu <= i_cfg_data;
              CFG_DT:  r_dt <= i_cfg_data[3:0];
              CFG_X0:  r_x  <= i_cfg_data;
              CFG_Y0:  r_y  <= i_cfg_data;
              default: ;
            endcase
            r_sat <= 1'b0;
            r_cnt <= '0;
          end
        end
        S_SQ, S_MU, S_DY: begin
          r_p <= w_mul_p;
          if (w_mul_ovf || (r_state == S_MU && w_omp_ovf)) r_sat <= 1'b1;
        end
        S_UPD: begin
          r_x     <= w_x_nxt;
          r_y     <= w_y_nxt;
          r_valid <= 1'b1;
          r_cnt   <= r_cnt + CNT_W'(1);
          if (w_x_ovf || w_d_ovf || w_y_ovf) r_sat <= 1'b1;
        end
        S_HOLD: begin
          if (r_valid && i_out_ready) r_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign o_out_valid = r_valid;
  assign o_x_out     = r_x;
  assign o_y_out     = r_y;
  assign o_busy      = (r_state != S_IDLE);
  assign o_sat       = r_sat;
  assign o_step_cnt  = r_cnt;

endmodule
